// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, 2 write ports, pending-producer scoreboard.
// Writes and scoreboard updates land on the next edge; define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp #(
  parameter int DATAWIDTH = 32,
  parameter int NREGS     = 32,
  parameter int ADDRW     = 5,
  parameter int NRD       = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD*ADDRW-1:0]     rd_addr,
  output logic [NRD*DATAWIDTH-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDRW-1:0]       wr_addr,
  input  logic [2*DATAWIDTH-1:0]   wr_data,
  input  logic                     alloc_en,
  input  logic [ADDRW-1:0]         alloc_addr,
  input  logic                     flush,
  output logic [ADDRW:0]           pend_cnt
);

  if ((2**ADDRW != NREGS) || (NREGS < 2) || (NREGS > 64) || (NRD < 1) || (NRD > 6)) begin : g_bad_cfg
    $error("regfile_mp: illegal parameter combination");
  end

  logic [DATAWIDTH-1:0] r_mem [NREGS];
  logic [NREGS-1:0]     r_pend;
  logic [ADDRW:0]       r_pend_cnt;

  logic [NREGS-1:0]     w_pend_nxt;
  logic [ADDRW:0]       w_pend_cnt_nxt;
  logic [1:0]           w_wr_act;
  logic [ADDRW-1:0]     w_wa [2];
  logic [DATAWIDTH-1:0] w_wd [2];
  logic                 w_alloc_act;

  // Writes to register 0 are dropped here, so nothing downstream needs to special-case them.
  for (genvar j = 0; j < 2; j++) begin : g_wr
    assign w_wa[j]     = wr_addr[j*ADDRW +: ADDRW];
    assign w_wd[j]     = wr_data[j*DATAWIDTH +: DATAWIDTH];
    assign w_wr_act[j] = wr_en[j] && (w_wa[j] != '0);
  end

  assign w_alloc_act = alloc_en && (alloc_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      if (w_wr_act[0]) r_mem[w_wa[0]] <= w_wd[0];
      if (w_wr_act[1]) r_mem[w_wa[1]] <= w_wd[1];
    end
  end

  // Allocation is applied after the write clears: it names a newer producer than the one retiring.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int j = 0; j < 2; j++) begin
      if (w_wr_act[j]) w_pend_nxt[w_wa[j]] = 1'b0;
    end
    if (w_alloc_act) w_pend_nxt[alloc_addr] = 1'b1;
    if (flush) w_pend_nxt = '0;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_pend_cnt_nxt = '0;
    for (int k = 0; k < NREGS; k++) begin
      w_pend_cnt_nxt = w_pend_cnt_nxt + {{ADDRW{1'b0}}, w_pend_nxt[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_pend_cnt_nxt;
    end
  end

  assign pend_cnt = r_pend_cnt;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDRW-1:0]     w_ra;
    logic                 w_ra_nz;
    logic [DATAWIDTH-1:0] w_rdat;
    logic                 w_rbusy;

    assign w_ra    = rd_addr[i*ADDRW +: ADDRW];
    assign w_ra_nz = (w_ra != '0);

`ifdef REGFILE_BYPASS_EN
    logic w_hit0;
    logic w_hit1;

    // w_wr_act already excludes address 0, so register 0 is never forwarded.
    assign w_hit0 = w_wr_act[0] && (w_wa[0] == w_ra);
    assign w_hit1 = w_wr_act[1] && (w_wa[1] == w_ra);

    always_comb begin
      w_rdat  = '0;
      w_rbusy = 1'b0;
      if (w_hit1) begin
        w_rdat = w_wd[1];
      end else if (w_hit0) begin
        w_rdat = w_wd[0];
      end else if (w_ra_nz) begin
        w_rdat  = r_mem[w_ra];
        w_rbusy = r_pend[w_ra];
      end
    end
`else
    always_comb begin
      w_rdat  = '0;
      w_rbusy = 1'b0;
      if (w_ra_nz) begin
        w_rdat  = r_mem[w_ra];
        w_rbusy = r_pend[w_ra];
      end
    end
`endif

    assign rd_data[i*DATAWIDTH +: DATAWIDTH] = w_rdat;
    assign rd_busy[i]                        = w_rbusy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters, bypass-aware).
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic             clk;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [1:0]       wr_en;
  logic [2*AW-1:0]  wr_addr;
  logic [2*DW-1:0]  wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             flush;
  logic [AW:0]      pend_cnt;

  int n_total = 0;
  int n_bad   = 0;

  regfile_mp #(.DATAWIDTH(DW), .NREGS(32), .ADDRW(AW), .NRD(NR)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .pend_cnt   (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] dat(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[j]             = 1'b1;
    wr_addr[j*AW +: AW]  = a;
    wr_data[j*DW +: DW]  = d;
  endtask

  task automatic set_alloc(input logic [AW-1:0] a);
    alloc_en   = 1'b1;
    alloc_addr = a;
  endtask

  // One clock: inputs held through the edge, then cleared just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    wr_en    = '0;
    alloc_en = 1'b0;
    flush    = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;

    // Activity during reset must be ignored.
    set_wr(0, 5'd3, 32'hDEAD_BEEF);
    set_alloc(5'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pend_cnt", 64'(pend_cnt), 64'd0);
    wr_en = '0; alloc_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int a = 0; a < 32; a++) begin
      for (int p = 0; p < NR; p++) set_rd(p, 5'(a));
      #1;
      chk($sformatf("rst_data_%0d", a), 64'(rd_data), 64'd0);
      chk($sformatf("rst_busy_%0d", a), 64'(rd_busy), 64'd0);
    end
    tick();

    set_wr(0, 5'd1, 32'h1111_1111);
    set_wr(1, 5'd2, 32'h2222_2222);
    tick();
    set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd1);
    #1;
    chk("wr_p0_r1", 64'(dat(0)), 64'h1111_1111);
    chk("wr_p1_r2", 64'(dat(1)), 64'h2222_2222);
    chk("wr_p2_r1", 64'(dat(2)), 64'h1111_1111);

    set_wr(0, 5'd5, 32'hAAAA_0000);
    set_wr(1, 5'd5, 32'h1234_5678);
    tick();
    set_rd(2, 5'd5);
    #1;
    chk("dual_conflict_r5", 64'(dat(2)), 64'h1234_5678);

    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 5'd0, 32'hFFFF_FFFF);
    set_alloc(5'd0);
    tick();
    set_rd(0, 5'd0);
    #1;
    chk("x0_data", 64'(dat(0)), 64'd0);
    chk("x0_busy", 64'(rd_busy[0]), 64'd0);
    chk("x0_pend_cnt", 64'(pend_cnt), 64'd0);

    set_alloc(5'd7);
    tick();
    set_rd(1, 5'd7);
    #1;
    chk("alloc7_cnt", 64'(pend_cnt), 64'd1);
    chk("alloc7_busy", 64'(rd_busy[1]), 64'd1);

    set_alloc(5'd7);
    set_wr(0, 5'd7, 32'h0000_0099);
    tick();
    #1;
    chk("realloc7_cnt", 64'(pend_cnt), 64'd1);
    chk("realloc7_busy", 64'(rd_busy[1]), 64'd1);
    chk("realloc7_data", 64'(dat(1)), 64'h99);

    set_wr(1, 5'd7, 32'h0000_0042);
    tick();
    #1;
    chk("wr7_busy", 64'(rd_busy[1]), 64'd0);
    chk("wr7_data", 64'(dat(1)), 64'h42);
    chk("wr7_cnt", 64'(pend_cnt), 64'd0);

    set_alloc(5'd3); tick();
    set_alloc(5'd4); tick();
    set_alloc(5'd9); tick();
    set_alloc(5'd3); tick();
    chk("alloc_349_cnt", 64'(pend_cnt), 64'd3);
    set_rd(0, 5'd3); set_rd(1, 5'd4); set_rd(2, 5'd9);
    #1;
    chk("alloc_349_busy", 64'(rd_busy), 64'b111);

    flush = 1'b1;
    set_alloc(5'd10);
    set_wr(0, 5'd12, 32'h0000_000C);
    tick();
    set_rd(2, 5'd10);
    #1;
    chk("flush_cnt", 64'(pend_cnt), 64'd0);
    chk("flush_busy", 64'(rd_busy), 64'b000);
    set_rd(0, 5'd12);
    #1;
    chk("flush_wr_commit", 64'(dat(0)), 64'hC);

    set_wr(0, 5'd6, 32'h0000_0600);
    tick();
    set_alloc(5'd6);
    tick();
    chk("alloc6_cnt", 64'(pend_cnt), 64'd1);
    set_rd(1, 5'd6);
    set_wr(0, 5'd6, 32'h0000_BEEF);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("fwd_data", 64'(dat(1)), 64'hBEEF);
    chk("fwd_busy", 64'(rd_busy[1]), 64'd0);
    set_wr(1, 5'd6, 32'h0000_F00D);
    #1;
    chk("fwd_p1_prio", 64'(dat(1)), 64'hF00D);
    wr_en[1] = 1'b0;
    #1;
`else
    chk("nofwd_data", 64'(dat(1)), 64'h600);
    chk("nofwd_busy", 64'(rd_busy[1]), 64'd1);
`endif
    tick();
    chk("wr6_data", 64'(dat(1)), 64'hBEEF);
    chk("wr6_busy", 64'(rd_busy[1]), 64'd0);
    chk("wr6_cnt", 64'(pend_cnt), 64'd0);

    // Reset arriving mid-cycle drops that cycle's write and allocation.
    set_alloc(5'd11);
    tick();
    set_wr(0, 5'd8, 32'h0000_0088);
    set_alloc(5'd13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cnt_async", 64'(pend_cnt), 64'd0);
    @(posedge clk);
    #1;
    wr_en = '0; alloc_en = 1'b0;
    set_rd(0, 5'd8); set_rd(1, 5'd5); set_rd(2, 5'd13);
    #1;
    chk("midrst_r8", 64'(dat(0)), 64'd0);
    chk("midrst_r5", 64'(dat(1)), 64'd0);
    chk("midrst_busy", 64'(rd_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cnt", 64'(pend_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
